// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic-light controller and its front-end blocks.
// Encodings that the controller already uses live here so every block agrees on them.
package tlc_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 8;
    localparam int CAR_CNT_W_DEF       = 4;

    typedef enum logic [1:0] {
        LOW_STABLE  = 2'd0,
        RISE_WAIT   = 2'd1,
        HIGH_STABLE = 2'd2,
        FALL_WAIT   = 2'd3
    } deb_state_t;

    // Lamp encoding driven onto the highway and farm-road signal heads.
    typedef enum logic [1:0] {
        LIGHT_GREEN  = 2'd0,
        LIGHT_YELLOW = 2'd1,
        LIGHT_RED    = 2'd2
    } light_t;

    typedef enum logic [1:0] {
        HWY_GREEN   = 2'd0,
        HWY_YELLOW  = 2'd1,
        FARM_GREEN  = 2'd2,
        FARM_YELLOW = 2'd3
    } ctrl_state_t;

    // Highway lamp colour for a given controller state.
    function automatic light_t hwy_light(input ctrl_state_t st);
        case (st)
            HWY_GREEN:  return LIGHT_GREEN;
            HWY_YELLOW: return LIGHT_YELLOW;
            default:    return LIGHT_RED;
        endcase
    endfunction

    // Farm-road lamp colour for a given controller state.
    function automatic light_t farm_light(input ctrl_state_t st);
        case (st)
            FARM_GREEN:  return LIGHT_GREEN;
            FARM_YELLOW: return LIGHT_YELLOW;
            default:     return LIGHT_RED;
        endcase
    endfunction

endpackage

// File: rtl/tlc_sensor_conditioner_if.sv
// Signal bundle between the traffic-light controller and the farm-road sensor conditioner.
interface tlc_sensor_conditioner_if #(
    parameter int CNT_W = 4
) ();
    import tlc_pkg::*;

    // No valid/ready pairs: sensor_raw and ena are levels, ack and clr_ovf are
    // single-cycle pulses taken on the edge they are high, and req, car_count
    // and overflow are registered levels valid just after each clk edge.
    logic             ena;
    logic             sensor_raw;
    logic             ack;
    logic             clr_ovf;
    logic             req;
    logic [CNT_W-1:0] car_count;
    logic             overflow;
    deb_state_t       dbg_state;

    modport master (
        output ena, sensor_raw, ack, clr_ovf,
        input  req, car_count, overflow, dbg_state
    );

    modport slave (
        input  ena, sensor_raw, ack, clr_ovf,
        output req, car_count, overflow, dbg_state
    );

endinterface

// File: rtl/tlc_sync2.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
module tlc_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/tlc_sensor_conditioner.sv
// Farm-road detector front end: synchronizes and debounces the raw sensor and keeps a
// saturating queue of waiting vehicles that the controller clears with ack.
module tlc_sensor_conditioner
    import tlc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CAR_CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    tlc_sensor_conditioner_if.slave   bus
);

    localparam int               DW        = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0]    DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             s_sync;
    deb_state_t       state_q, state_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic             arrive;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             req_q;

    tlc_sync2 #(.W(1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.sensor_raw),
        .q_o   (s_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOW_STABLE;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // dcnt counts consecutive samples at the new level; entering a WAIT state counts as the first.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        arrive  = 1'b0;
        if (bus.ena) begin
            case (state_q)
                LOW_STABLE: begin
                    if (s_sync) begin
                        state_d = RISE_WAIT;
                        dcnt_d  = DW'(1);
                    end
                end
                RISE_WAIT: begin
                    if (!s_sync) begin
                        state_d = LOW_STABLE;
                        dcnt_d  = '0;
                    end else if (dcnt_q == DCNT_LAST) begin
                        state_d = HIGH_STABLE;
                        dcnt_d  = '0;
                        arrive  = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                HIGH_STABLE: begin
                    if (!s_sync) begin
                        state_d = FALL_WAIT;
                        dcnt_d  = DW'(1);
                    end
                end
                FALL_WAIT: begin
                    if (s_sync) begin
                        state_d = HIGH_STABLE;
                        dcnt_d  = '0;
                    end else if (dcnt_q == DCNT_LAST) begin
                        state_d = LOW_STABLE;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = LOW_STABLE;
                    dcnt_d  = '0;
                end
            endcase
        end
    end

    // A coincident ack and arrival leaves exactly the newcomer queued.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (bus.ack && arrive) begin
            count_d = CNT_W'(1);
        end else if (bus.ack) begin
            count_d = '0;
        end else if (arrive) begin
            if (count_q != CNT_MAX) begin
                count_d = count_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            req_q   <= (count_d != '0);
        end
    end

    assign bus.req       = req_q;
    assign bus.car_count = count_q;
    assign bus.overflow  = ovf_q;
    assign bus.dbg_state = state_q;

endmodule

// File: doc/tlc_sensor_conditioner.md
# tlc_sensor_conditioner

Front-end stage for the highway/farm traffic-light controller. Converts the raw, asynchronous farm-road vehicle detector into a clean, debounced car-waiting request, `req`, which drives the controller's sensor input `C`. It also keeps a saturating count of vehicles queued since the last service acknowledge. The controller pulses `ack` when farm green is granted, and that pulse clears the queue.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 8: consecutive stable synchronized samples required to accept a level change; legal range ≥2.
- `CNT_W`, default 4: width of the vehicle queue counter.

Ports:
- `clk`  in  1  — clock.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `ena`  in  1  — block enable; when low, the debounce FSM and the counter are frozen.
- `sensor_raw`  in  1  — raw vehicle detector, asynchronous to `clk`, may bounce.
- `ack`  in  1  — single-cycle pulse from the controller: queued vehicles served.
- `clr_ovf`  in  1  — single-cycle pulse that clears `overflow`.
- `req`  out  1  — registered; high while `car_count != 0`; feeds controller `C`.
- `car_count`  out  `CNT_W`  — registered; vehicles waiting; saturating.
- `overflow`  out  1  — registered; sticky; set when an arrival occurs while the count is already at maximum.

## Operation

- **Synchronizer.** `sensor_raw` passes through a 2-FF synchronizer, giving `s_sync`. The synchronizer runs regardless of `ena`.
- **Debounce FSM.** Four states: `LOW_STABLE`, `RISE_WAIT`, `HIGH_STABLE`, `FALL_WAIT`. A stability counter `dcnt` uses `$clog2(DEBOUNCE_CYCLES)` bits.
  - `LOW_STABLE`: if `s_sync=1`, go to `RISE_WAIT` with `dcnt=1`.
  - `RISE_WAIT`:
    - If `s_sync=0`, go to `LOW_STABLE` with `dcnt=0`.
    - Else if `dcnt==DEBOUNCE_CYCLES-1`, go to `HIGH_STABLE`, assert `arrive` (combinational, one cycle) and set `dcnt=0`.
    - Else increment `dcnt`.
  - `HIGH_STABLE` and `FALL_WAIT` mirror the above with polarity swapped. The `FALL_WAIT`→`LOW_STABLE` transition produces no event.
- **Counter update**, priority order:
  - `ack` and `arrive` in the same cycle: count=1.
  - `ack` alone: count=0.
  - `arrive` alone: if count<2^CNT_W−1, count+1; else hold and set `overflow`.
- **Enable.** When `ena=0`, the FSM state, `dcnt` and `arrive` are frozen (`arrive` forced 0). `ack` is still honoured. `req` keeps tracking `car_count`.
- **Overflow.** `clr_ovf` clears `overflow`. If `clr_ovf` and an overflow event occur in the same cycle, set wins.
- **Reset values.** `req=0`, `car_count=0`, `overflow=0`, FSM=`LOW_STABLE`, `dcnt=0`, synchronizer flops=0. Reset is asynchronous and may be asserted mid-debounce; on release the FSM restarts from `LOW_STABLE`.

## Timing

- Raw-to-request latency, edges counted from the first edge sampling `sensor_raw=1`, raw held stable:
  - `s_sync` is high after edge 2.
  - FSM enters `RISE_WAIT` at edge 3.
  - `arrive` and the counter update occur at edge `DEBOUNCE_CYCLES+2`.
  - `req` and `car_count` are valid after that edge, i.e. after edge 10 for the default.
- `req` is registered in the same flop stage as `car_count`; there is no extra delay between them.
- `ack` to `req` deassert: one edge, provided there is no coincident arrival.
- Any high excursion shorter than `DEBOUNCE_CYCLES` synchronized samples produces no arrival. The same rule applies to low excursions and the return to `LOW_STABLE`.
- Back-to-back vehicles require at least `DEBOUNCE_CYCLES` low samples between high periods to be counted separately.

## Structure

- **Shared package `tlc_pkg`:**
  - Debounce state enum (`LOW_STABLE`, `RISE_WAIT`, `HIGH_STABLE`, `FALL_WAIT`, 2-bit).
  - Default `DEBOUNCE_CYCLES` constant.
  - The existing controller's light and state encodings, moved here so both blocks share them.
- **Sub-module `tlc_sync2`:** generic 2-FF synchronizer with async active-low reset, reused for any future pedestrian-button input.
- The debounce FSM, counter and overflow logic stay in the top module.

## Test plan

All scenarios use the defaults (`DEBOUNCE_CYCLES=8`, `CNT_W=4`) unless stated.

1. **Reset.** Hold `rst_n=0` with `sensor_raw=1` toggling → `req=0`, `car_count=0`, `overflow=0` throughout. After release with raw low → outputs remain 0.
2. **Clean arrival.** Raise `sensor_raw` and hold for 20 cycles → `car_count` 0→1 and `req` 0→1 exactly after edge 10. Falling edge → no count change.
3. **Glitch rejection.** Raw high for 5 cycles, then low; separately, 3 bursts of 2 cycles with 1-cycle gaps → `car_count` stays 0 and `req` stays 0.
4. **Queue and service.** 3 clean pulses (12 high / 12 low each) → `car_count=3`. Then pulse `ack` → `car_count=0` and `req=0` after one edge.
5. **Saturation and overflow.** 16 clean pulses → `car_count=15`, `overflow=1`, `req=1`. Then pulse `clr_ovf` → `overflow=0`, count still 15.
6. **Simultaneous events, enable and mid-operation reset.**
   - `ack` coincident with an arrival edge → `car_count=1`, `req` stays 1.
   - `ena=0` during a full raw pulse → no count.
   - Assert `rst_n` in `RISE_WAIT` → all outputs 0 immediately; no arrival occurs afterwards unless raw is held for the full latency again.
